tcm_trigger_rx: RTL and testbench

TCM_TRIGGER_RX -- requirements
Module: tcm_trigger_rx

---
 rtl/tcm_trigger_rx.sv | 208 ++++++++++++++++++++
 tb/tb_tcm_trigger_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tcm_trigger_rx.sv
// tcm_trigger_rx: deserialises the PM trigger (tt) and amplitude (ta) lanes,
// classifies each tt frame, tracks link lock and reports decoded data.
module tcm_trigger_rx #(
  parameter int unsigned LOCK_GOOD  = 4,
  parameter int unsigned UNLOCK_BAD = 2
) (
  input  logic        clk320,
  input  logic        rst,
  input  logic [2:0]  mt_cou,
  input  logic        en,
  input  logic        clr_cnt,
  input  logic        tt,
  input  logic        ta,
  output logic        tcm_req,
  output logic [5:0]  trig_bits,
  output logic [7:0]  ampl_sum,
  output logic        data_valid,
  output logic        frame_err,
  output logic        locked,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {StIdle, StSearch, StCheck, StLocked} state_e;

  // Lock/unlock thresholds are expected to stay well below 256.
  localparam logic [7:0] LockGoodC  = 8'(LOCK_GOOD);
  localparam logic [7:0] UnlockBadC = 8'(UNLOCK_BAD);

  state_e      state_q, state_d;
  logic [6:0]  tt_sr_q, tt_sr_d;
  logic [6:0]  ta_sr_q, ta_sr_d;
  logic        armed_q, armed_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_tt_q, pend_tt_d;
  logic [7:0]  pend_ta_q, pend_ta_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  bad_cnt_q, bad_cnt_d;
  logic [5:0]  trig_q, trig_d;
  logic [7:0]  ampl_q, ampl_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;
  logic        locked_q, locked_d;
  logic        req_q, req_d;
  logic [15:0] err_q, err_d;

  logic is_idle, is_data, is_good;

  // Classification of the frame captured at the previous mt_cou=7 sample.
  always_comb begin
    is_idle = (pend_tt_q == 8'h00);
    is_data = pend_tt_q[7] & (^pend_tt_q);
    is_good = is_idle | is_data;
  end

  // Next-state: deserialiser, frame pipeline, lock FSM, outputs.
  always_comb begin
    state_d    = state_q;
    tt_sr_d    = tt_sr_q;
    ta_sr_d    = ta_sr_q;
    armed_d    = armed_q;
    pend_d     = 1'b0;
    pend_tt_d  = pend_tt_q;
    pend_ta_d  = pend_ta_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    trig_d     = trig_q;
    ampl_d     = ampl_q;
    dv_d       = 1'b0;
    fe_d       = 1'b0;
    err_d      = err_q;

    if (!en) begin
      // Link disabled: drop everything in flight, keep the data/err outputs.
      state_d    = StIdle;
      tt_sr_d    = '0;
      ta_sr_d    = '0;
      armed_d    = 1'b0;
      pend_tt_d  = '0;
      pend_ta_d  = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      tt_sr_d = {tt_sr_q[5:0], tt};
      ta_sr_d = {ta_sr_q[5:0], ta};
      // A frame is only trusted once its first bit was seen at mt_cou=0.
      if (mt_cou == 3'd0) armed_d = 1'b1;
      if (armed_q && (mt_cou == 3'd7)) begin
        pend_d    = 1'b1;
        pend_tt_d = {tt_sr_q, tt};
        pend_ta_d = {ta_sr_q, ta};
      end

      unique case (state_q)
        StIdle: state_d = StSearch;
        StSearch: begin
          if (pend_q) begin
            if (is_good) begin
              if (LockGoodC <= 8'd1) begin
                state_d    = StLocked;
                good_cnt_d = '0;
              end else begin
                state_d    = StCheck;
                good_cnt_d = 8'd1;
              end
            end else begin
              fe_d = 1'b1;
            end
          end
        end
        StCheck: begin
          if (pend_q) begin
            if (is_good) begin
              if (good_cnt_q + 8'd1 >= LockGoodC) begin
                state_d    = StLocked;
                good_cnt_d = '0;
              end else begin
                good_cnt_d = good_cnt_q + 8'd1;
              end
            end else begin
              state_d    = StSearch;
              good_cnt_d = '0;
              fe_d       = 1'b1;
            end
          end
        end
        StLocked: begin
          if (pend_q) begin
            if (is_good) begin
              bad_cnt_d = '0;
              if (is_data) begin
                dv_d   = 1'b1;
                trig_d = pend_tt_q[6:1];
                ampl_d = pend_ta_q;
              end
            end else begin
              fe_d = 1'b1;
              if (bad_cnt_q + 8'd1 >= UnlockBadC) begin
                state_d   = StSearch;
                bad_cnt_d = '0;
              end else begin
                bad_cnt_d = bad_cnt_q + 8'd1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Clear has priority over a same-cycle increment.
    if (clr_cnt) begin
      err_d = '0;
    end else if (fe_d && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end

    locked_d = (state_d == StLocked);
    req_d    = (state_d != StIdle);
  end

  // State and output registers, asynchronous active-high reset.
  always_ff @(posedge clk320 or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tt_sr_q    <= '0;
      ta_sr_q    <= '0;
      armed_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tt_q  <= '0;
      pend_ta_q  <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      trig_q     <= '0;
      ampl_q     <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
      locked_q   <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      tt_sr_q    <= tt_sr_d;
      ta_sr_q    <= ta_sr_d;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      pend_tt_q  <= pend_tt_d;
      pend_ta_q  <= pend_ta_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      trig_q     <= trig_d;
      ampl_q     <= ampl_d;
      dv_q       <= dv_d;
      fe_q       <= fe_d;
      locked_q   <= locked_d;
      req_q      <= req_d;
      err_q      <= err_d;
    end
  end

  assign tcm_req    = req_q;
  assign trig_bits  = trig_q;
  assign ampl_sum   = ampl_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign locked     = locked_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_tcm_trigger_rx.sv
// Directed bench for tcm_trigger_rx: frame table plus hand-written corner cases.
module tb_tcm_trigger_rx;

  logic        clk320 = 1'b0;
  logic        rst;
  logic [2:0]  mt_cou;
  logic        en, clr_cnt, tt, ta;
  logic        tcm_req, data_valid, frame_err, locked;
  logic [5:0]  trig_bits;
  logic [7:0]  ampl_sum;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Outputs captured one clk after a frame's mt_cou=7 edge (first clk of next frame).
  logic        r_dv, r_fe, r_lk, r_req;
  logic [5:0]  r_trig;
  logic [7:0]  r_amp;
  logic [15:0] r_err;
  logic        r_dv1, r_fe1, r_dv7, r_fe7;

  typedef struct {
    logic [7:0]  tt;
    logic [7:0]  ta;
    logic        dv;
    logic        fe;
    logic        lk;
    logic [5:0]  trig;
    logic [7:0]  amp;
    logic [15:0] err;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  tcm_trigger_rx #(.LOCK_GOOD(4), .UNLOCK_BAD(2)) dut (
    .clk320     (clk320),
    .rst        (rst),
    .mt_cou     (mt_cou),
    .en         (en),
    .clr_cnt    (clr_cnt),
    .tt         (tt),
    .ta         (ta),
    .tcm_req    (tcm_req),
    .trig_bits  (trig_bits),
    .ampl_sum   (ampl_sum),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .locked     (locked),
    .err_cnt    (err_cnt)
  );

  always #5 clk320 = ~clk320;

  task automatic tick();
    @(posedge clk320);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [7:0] a);
    for (int i = 0; i < 8; i++) begin
      mt_cou = 3'(i);
      tt     = t[7-i];
      ta     = a[7-i];
      tick();
      if (i == 0) begin
        r_dv = data_valid; r_fe = frame_err; r_lk = locked; r_req = tcm_req;
        r_trig = trig_bits; r_amp = ampl_sum; r_err = err_cnt;
      end
      if (i == 1) begin r_dv1 = data_valid; r_fe1 = frame_err; end
      if (i == 7) begin r_dv7 = data_valid; r_fe7 = frame_err; end
    end
  endtask

  task automatic check_vec(input int k);
    chk($sformatf("v%0d_dv", k),   32'(r_dv),   32'(vecs[k].dv));
    chk($sformatf("v%0d_fe", k),   32'(r_fe),   32'(vecs[k].fe));
    chk($sformatf("v%0d_lk", k),   32'(r_lk),   32'(vecs[k].lk));
    chk($sformatf("v%0d_req", k),  32'(r_req),  32'h1);
    chk($sformatf("v%0d_trig", k), 32'(r_trig), 32'(vecs[k].trig));
    chk($sformatf("v%0d_amp", k),  32'(r_amp),  32'(vecs[k].amp));
    chk($sformatf("v%0d_err", k),  32'(r_err),  32'(vecs[k].err));
    chk($sformatf("v%0d_pulse1", k), 32'({r_dv1, r_fe1}), 32'h0);
  endtask

  initial begin
    //             tt     ta     dv    fe    lk    trig   amp    err
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0};
    vecs[1]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0};
    vecs[2]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 6'h00, 8'h00, 16'd0};
    vecs[4]  = '{8'hDA, 8'h5C, 1'b1, 1'b0, 1'b1, 6'h2D, 8'h5C, 16'd0};
    vecs[5]  = '{8'h00, 8'hAA, 1'b0, 1'b0, 1'b1, 6'h2D, 8'h5C, 16'd0};
    vecs[6]  = '{8'hDB, 8'h00, 1'b0, 1'b1, 1'b1, 6'h2D, 8'h5C, 16'd1};
    vecs[7]  = '{8'hDB, 8'h00, 1'b0, 1'b1, 1'b0, 6'h2D, 8'h5C, 16'd2};
    vecs[8]  = '{8'h80, 8'h77, 1'b0, 1'b0, 1'b0, 6'h2D, 8'h5C, 16'd2};
    vecs[9]  = '{8'h80, 8'h77, 1'b0, 1'b0, 1'b0, 6'h2D, 8'h5C, 16'd2};
    vecs[10] = '{8'h80, 8'h77, 1'b0, 1'b0, 1'b0, 6'h2D, 8'h5C, 16'd2};
    vecs[11] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 6'h2D, 8'h5C, 16'd3};
    vecs[12] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'h2D, 8'h5C, 16'd3};
    vecs[13] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'h2D, 8'h5C, 16'd3};
    vecs[14] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'h2D, 8'h5C, 16'd3};
    vecs[15] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 6'h2D, 8'h5C, 16'd3};
    vecs[16] = '{8'h83, 8'hF0, 1'b1, 1'b0, 1'b1, 6'h01, 8'hF0, 16'd3};
    vecs[17] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 6'h01, 8'hF0, 16'd4};
    vecs[18] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 6'h01, 8'hF0, 16'd4};
    vecs[19] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 6'h01, 8'hF0, 16'd5};
    vecs[20] = '{8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 6'h01, 8'hF0, 16'd6};
    vecs[21] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'h01, 8'hF0, 16'd6};

    rst = 1'b1; mt_cou = 3'd0; en = 1'b0; clr_cnt = 1'b0; tt = 1'b0; ta = 1'b0;
    #1;
    chk("rst_req",  32'(tcm_req),    32'h0);
    chk("rst_trig", 32'(trig_bits),  32'h0);
    chk("rst_amp",  32'(ampl_sum),   32'h0);
    chk("rst_dv",   32'(data_valid), 32'h0);
    chk("rst_fe",   32'(frame_err),  32'h0);
    chk("rst_lk",   32'(locked),     32'h0);
    chk("rst_err",  32'(err_cnt),    32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Main table: frame k's result is observed during frame k+1; last send flushes.
    en = 1'b1;
    for (int k = 0; k <= NVEC; k++) begin
      if (k < NVEC) send_frame(vecs[k].tt, vecs[k].ta);
      else          send_frame(8'h00, 8'h00);
      if (k > 0) check_vec(k - 1);
      if (k < NVEC) chk($sformatf("v%0d_latency", k), 32'({r_dv7, r_fe7}), 32'h0);
    end

    // Saturation: mt_cou held at 7 with tt=1 closes an all-ones bad frame every clk.
    mt_cou = 3'd7; tt = 1'b1; ta = 1'b0;
    for (int i = 0; i < 65600; i++) tick();
    chk("sat_ffff", 32'(err_cnt), 32'hFFFF);
    for (int i = 0; i < 16; i++) tick();
    chk("sat_hold", 32'(err_cnt), 32'hFFFF);
    chk("sat_fe_strobe", 32'(frame_err), 32'h1);
    chk("sat_no_dv", 32'(data_valid), 32'h0);
    clr_cnt = 1'b1;
    tick();
    chk("clr_wins", 32'(err_cnt), 32'h0);
    clr_cnt = 1'b0; en = 1'b0; mt_cou = 3'd0; tt = 1'b0;
    tick();
    chk("en0_err_hold", 32'(err_cnt), 32'h0);
    chk("en0_req", 32'(tcm_req), 32'h0);
    tick(); tick();

    // en rises at mt_cou=3: the partial frame (would decode as 0x1F) is ignored.
    for (int i = 0; i < 8; i++) begin
      mt_cou = 3'(i); en = (i >= 3); tt = 1'b1; ta = 1'b1;
      tick();
    end
    send_frame(8'h00, 8'h00);
    chk("partial_fe", 32'(r_fe), 32'h0);
    chk("partial_err", 32'(r_err), 32'h0);
    chk("partial_req", 32'(r_req), 32'h1);
    send_frame(8'h00, 8'h00);
    send_frame(8'h00, 8'h00);
    send_frame(8'h00, 8'h00);
    send_frame(8'hC1, 8'h3C);
    chk("en3_locked", 32'(r_lk), 32'h1);
    send_frame(8'h00, 8'h00);
    chk("en3_dv", 32'(r_dv), 32'h1);
    chk("en3_data", 32'({r_trig, r_amp}), 32'({6'h20, 8'h3C}));
    en = 1'b0;
    tick();
    chk("dis_locked", 32'(locked), 32'h0);
    chk("dis_req", 32'(tcm_req), 32'h0);
    chk("dis_held", 32'({trig_bits, ampl_sum}), 32'({6'h20, 8'h3C}));

    // Relock, then reset in the middle of a DATA frame.
    en = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      mt_cou = 3'(i); tt = 8'hDA >> (7 - i); ta = 8'h99 >> (7 - i);
      tick();
      if (i == 0) chk("pre_rst_locked", 32'(locked), 32'h1);
      if (i == 4) begin
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({tcm_req, trig_bits, ampl_sum, data_valid, frame_err,
                                 locked}), 32'h0);
        chk("mid_rst_err", 32'(err_cnt), 32'h0);
        #1 rst = 1'b0;
      end
    end
    begin
      logic seen_dv;
      seen_dv = 1'b0;
      for (int i = 0; i < 16; i++) begin
        mt_cou = 3'(i % 8); tt = 1'b0; ta = 1'b0;
        tick();
        if (data_valid || locked) seen_dv = 1'b1;
      end
      chk("post_rst_quiet", 32'(seen_dv), 32'h0);
      chk("post_rst_trig", 32'(trig_bits), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
